uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Serial transmitter downstream of the cpu core. Drives the top-level uart pin.
//  Accepts bytes from the cpu's memory-mapped store path and buffers them in a FIFO.
//  Shifts each byte out as an 8N1 frame: start bit, 8 data bits LSB-first, stop bit.
//  Lets the cpu issue print bursts without stalling on each byte.
// PARAMETERS
//  CLK_FREQ    10_000_000  system clock frequency in Hz
//  BAUD        115_200     line rate; bit period DIV = CLK_FREQ/BAUD, truncated (86 at defaults)
//  FIFO_DEPTH  16          byte entries; power of two, >= 2
// PORTS
//  clk       in   1  system clock; all state updates on its rising edge
//  rst       in   1  asynchronous reset, active-low (0 = reset)
//  wr_en     in   1  cpu write strobe; one byte per cycle while high
//  wr_data   in   8  byte to transmit
//  full      out  1  FIFO holds FIFO_DEPTH entries (registered count)
//  tx_busy   out  1  high when the FSM is not IDLE or the FIFO is non-empty
//  overflow  out  1  sticky; set by wr_en while full; cleared only by reset
//  uart      out  1  serial line, idle high, registered output
// BEHAVIOUR
//  Reset, asynchronous and effective immediately:
//   - uart=1, full=0, tx_busy=0, overflow=0
//   - FIFO empty, pointers=0, FSM=IDLE, bit counter=0, baud counter=0
//   - A frame cut by reset is abandoned. The line returns high at once.
//  FIFO:
//   - wr_en with full=1: write dropped, overflow<=1.
//   - Full test uses the registered count only. A write is rejected even if a pop
//     happens in the same cycle.
//   - Write and pop in the same cycle with count>=1: both take effect, count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits wide.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//   - IDLE: if count>0, pop the head into the shift register, go to START,
//     and drive uart<=0 on the same edge.
//   - Latency: a write sampled at edge k into an empty FIFO with the FSM in IDLE
//     gives uart low from edge k+1.
//   - Each state holds for exactly DIV cycles, timed by the baud counter
//     (0..DIV-1, reload on wrap).
//   - DATA: 8 bits, LSB first; a 3-bit index counts 0..7.
//   - STOP: uart=1 for DIV cycles.
//   - At the end of STOP, if count>0, pop and enter START directly (no idle gap);
//     otherwise enter IDLE.
//   - wr_en during a frame never disturbs the frame in flight.
//   - Frame length is 10*DIV cycles (11*DIV with parity).
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - PARITY state inserted after DATA.
//   - Drives even parity (^data) for DIV cycles; frame is 8E1, 11 bits.
//  Undefined:
//   - No PARITY state, no parity logic; frame is 8N1, 10 bits.
// STRUCTURE
//  Package uart_pkg holds:
//   - FSM state enum: IDLE, START, DATA, PARITY, STOP.
//   - DATA_BITS=8 and FRAME_BITS (10 or 11, per macro).
//  Sub-module uart_fifo: synchronous FIFO, parameter DEPTH.
//   - Ports: clk, rst, push, pop, din, dout, count, full, empty.
//   - Dout is combinational from the head entry.
//  Top level holds the baud counter, FSM, shift register and output register.
// TESTING
//  Use BAUD chosen so DIV=4 unless noted.
//  1 Reset then idle, no writes for 100 cycles
//    -> uart=1, tx_busy=0, full=0, overflow=0 throughout.
//  2 Single write 0xA5 at edge k
//    -> uart low from edge k+1 for 4 cycles.
//    -> Then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles.
//    -> tx_busy falls at edge k+41.
//  3 Write 0x41 then 0x42 on consecutive cycles
//    -> Frame two's start bit follows frame one's stop bit with no idle cycles.
//    -> tx_busy stays high for 80 cycles.
//  4 Write 17 bytes back-to-back while the FSM is busy
//    -> full=1 after the FIFO fills. The 17th write is dropped and overflow=1.
//    -> Exactly 17 frames go out: 1 popped into the shifter plus 16 buffered.
//    -> Adjust the count if the first pop precedes fill.
//  5 Assert rst=0 mid-DATA of a frame
//    -> uart=1 immediately, FIFO empty; after release the line stays idle.
//  6 With UART_TX_PARITY_EN, write 0x07
//    -> Parity bit = 1 after data bits; frame is 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx_fifo transmitter.
// Define UART_TX_PARITY_EN to build the 8E1 variant with an even-parity bit.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction
`else
   localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with a registered occupancy count and a
// combinational read port on the head entry.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_BITS-1:0]       din,
   output logic [DATA_BITS-1:0]       dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q;
   logic [AW-1:0]        rd_ptr_q;
   logic [AW:0]          count_q;
   logic [AW:0]          count_d;
   logic                 push_ok_s;
   logic                 pop_ok_s;

   // A write while full is refused even if a pop frees a slot on the same edge.
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_s) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok_s) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding an 8N1 (8E1 with UART_TX_PARITY_EN)
// serializer with a registered line output.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 10_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic                 full,
   output logic                 tx_busy,
   output logic                 overflow,
   output logic                 uart
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam int NW  = $clog2(FIFO_DEPTH) + 1;

   uart_state_e          state_q;
   logic [CW-1:0]        baud_cnt_q;
   logic [2:0]           bit_idx_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 uart_q;
   logic                 overflow_q;

   logic                 bit_end_s;
   logic                 pop_s;
   logic [DATA_BITS-1:0] fifo_dout_s;
   logic [NW-1:0]        fifo_count_s;
   logic                 fifo_full_s;
   logic                 fifo_empty_s;

   uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en),
      .pop   (pop_s),
      .din   (wr_data),
      .dout  (fifo_dout_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign bit_end_s = (baud_cnt_q == DIV_LAST);

   // Pops happen only from IDLE or at the last cycle of STOP, so back-to-back frames have no gap.
   assign pop_s = (fifo_count_s != '0) &&
                  ((state_q == IDLE) || ((state_q == STOP) && bit_end_s));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= 3'd0;
         data_q     <= '0;
         uart_q     <= 1'b1;
      end else begin
         baud_cnt_q <= ((state_q == IDLE) || bit_end_s) ? '0 : baud_cnt_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (pop_s) begin
                  data_q  <= fifo_dout_s;
                  state_q <= START;
                  uart_q  <= 1'b0;
               end
            end
            START: begin
               if (bit_end_s) begin
                  state_q   <= DATA;
                  bit_idx_q <= 3'd0;
                  uart_q    <= data_q[0];
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= PARITY;
                     uart_q  <= even_parity(data_q);
`else
                     state_q <= STOP;
                     uart_q  <= 1'b1;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     uart_q    <= data_q[bit_idx_q + 3'd1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end_s) begin
                  state_q <= STOP;
                  uart_q  <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end_s) begin
                  if (pop_s) begin
                     data_q  <= fifo_dout_s;
                     state_q <= START;
                     uart_q  <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     uart_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               uart_q  <= 1'b1;
            end
         endcase
      end
   end

   // Sticky: a refused write is remembered until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_q | (wr_en & fifo_full_s);
      end
   end

   assign full     = fifo_full_s;
   assign tx_busy  = (state_q != IDLE) | ~fifo_empty_s;
   assign overflow = overflow_q;
   assign uart     = uart_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: frame-level reference model plus a line receiver.
module tb_uart_tx_fifo;

   localparam int DIV   = 4;
   localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       wr_en   = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, tx_busy, overflow, uart;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state: FIFO contents, current frame byte, start edge and end edge
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic [7:0] cur_b  = 8'h00;
   int         cur_p  = 0;
   int         nxt    = 0;
   bit         ovf_m  = 1'b0;
   int         m_sz;

   bit               rx_act = 1'b0;
   int               rx_i   = 0;
   logic [FRAME-1:0] rx_bits;
   logic [7:0]       rx_exp;
   int               frames_rx = 0;
   int               frames_base;

   uart_tx_fifo #(.CLK_FREQ(10_000_000), .BAUD(2_500_000), .FIFO_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .tx_busy  (tx_busy),
      .overflow (overflow),
      .uart     (uart)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (k == FRAME - 1) return 1'b1;
      return ^b;
   endfunction

   // Reference model: one pop per frame period, writes refused while 16 are held.
   initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
         mq.delete();
         exp_q.delete();
         nxt   = 0;
         ovf_m = 1'b0;
      end else begin
         m_sz = mq.size();
         if (wr_en && m_sz == DEPTH) ovf_m = 1'b1;
         if (cyc >= nxt && m_sz > 0) begin
            cur_b = mq.pop_front();
            cur_p = cyc;
            nxt   = cyc + FRAME * DIV;
         end
         if (wr_en && m_sz < DEPTH) begin
            mq.push_back(wr_data);
            exp_q.push_back(wr_data);
         end
      end
   end

   // Monitor: per-cycle line/flag comparison and a mid-bit sampling receiver.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         rx_act = 1'b0;
         chk("uart_in_reset", uart, 1);
         chk("busy_in_reset", tx_busy, 0);
         chk("full_in_reset", full, 0);
         chk("ovf_in_reset", overflow, 0);
      end else begin
         chk("uart_line", uart, (cyc < nxt) ? frame_bit(cur_b, (cyc - cur_p) / DIV) : 1'b1);
         chk("tx_busy", tx_busy, (mq.size() > 0 || cyc < nxt) ? 1 : 0);
         chk("full", full, (mq.size() == DEPTH) ? 1 : 0);
         chk("overflow", overflow, ovf_m);
         if (!rx_act && uart == 1'b0) begin
            rx_act = 1'b1;
            rx_i   = 0;
         end
         if (rx_act) begin
            if (rx_i % DIV == DIV / 2) rx_bits[rx_i / DIV] = uart;
            rx_i++;
            if (rx_i == FRAME * DIV) begin
               rx_act = 1'b0;
               frames_rx++;
               chk("rx_start_bit", rx_bits[0], 0);
               chk("rx_stop_bit", rx_bits[FRAME-1], 1);
               chk("rx_frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
               if (exp_q.size() > 0) begin
                  rx_exp = exp_q.pop_front();
                  chk("rx_byte", rx_bits[8:1], rx_exp);
`ifdef UART_TX_PARITY_EN
                  chk("rx_parity", rx_bits[9], ^rx_exp);
`endif
               end
            end
         end
      end
   end

   task automatic drive(input logic en, input logic [7:0] d);
      @(negedge clk);
      wr_en   = en;
      wr_data = d;
   endtask

   task automatic drain(input int cap);
      int w;
      w = 0;
      drive(1'b0, 8'h00);
      while ((mq.size() > 0 || cyc < nxt) && w < cap) begin
         @(negedge clk);
         w++;
      end
      chk("drain_in_time", (w < cap) ? 1 : 0, 1);
      repeat (4) @(negedge clk);
      chk("drain_busy_low", tx_busy, 0);
      chk("drain_all_received", exp_q.size(), 0);
   endtask

   initial begin
      #1 rst = 1'b0;
      #2;
      chk("por_uart", uart, 1);
      chk("por_busy", tx_busy, 0);
      chk("por_full", full, 0);
      chk("por_ovf", overflow, 0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;

      // idle line
      repeat (100) drive(1'b0, 8'h00);

      // single byte, then two back-to-back bytes
      drive(1'b1, 8'hA5);
      drain(200);
      drive(1'b1, 8'h41);
      drive(1'b1, 8'h42);
      drain(300);

      // burst of 17 while a frame is in flight: 16 buffered, 17th refused
      frames_base = frames_rx;
      drive(1'b1, 8'h55);
      repeat (3) drive(1'b0, 8'h00);
      for (int i = 0; i < 17; i++) drive(1'b1, 8'($urandom));
      drive(1'b0, 8'h00);
      chk("burst_full", full, 1);
      chk("burst_overflow", overflow, 1);
      drain(2000);
      chk("burst_frames", frames_rx - frames_base, 17);

      // reset in the middle of a zero-data frame with bytes still queued
      for (int i = 0; i < 5; i++) drive(1'b1, 8'h00);
      drive(1'b0, 8'h00);
      repeat (12) @(negedge clk);
      chk("pre_reset_uart_low", uart, 0);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_uart", uart, 1);
      chk("async_rst_busy", tx_busy, 0);
      chk("async_rst_full", full, 0);
      chk("async_rst_ovf", overflow, 0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      frames_base = frames_rx;
      repeat (80) drive(1'b0, 8'h00);
      chk("post_reset_no_frames", frames_rx - frames_base, 0);

      // random traffic with occasional short bursts
      repeat (1500) begin
         if ($urandom_range(0, 59) == 0) begin
            repeat ($urandom_range(1, 6)) drive(1'b1, 8'($urandom));
         end else begin
            drive(1'b0, 8'h00);
         end
      end
      drain(3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
